// File: rtl/afifo_rd_stream.sv
// afifo_rd_stream: drains the async FIFO read port (read clock domain) into a valid/ready stream, counting delivered words.
// Latency: first word valid 2 cycles after re_o (1 FIFO read cycle + 1 buffer register), then one word per cycle.
// Backpressure: 2-entry output buffer; re_o is withheld once buffered + in-flight words would exceed 2, so nothing is dropped.
// Optional: define AFIFO_RD_STATS_EN to add stall_cnt_o and underrun_o.
module afifo_rd_stream #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_r,
   input  logic                  srst_n,
   input  logic                  en_i,
   input  logic                  flush_i,
   input  logic                  empty_i,
   input  logic [DATA_WIDTH-1:0] data_r_i,
   output logic                  re_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic [CNT_WIDTH-1:0]  count_o,
`ifdef AFIFO_RD_STATS_EN
   output logic [CNT_WIDTH-1:0]  stall_cnt_o,
   output logic                  underrun_o,
`endif
   output logic                  busy_o
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } occ_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   occ_t                  r_occ;
   logic                  r_inflight;
   logic [DATA_WIDTH-1:0] r_head;
   logic [DATA_WIDTH-1:0] r_tail;
   logic [CNT_WIDTH-1:0]  r_count;

   logic [1:0]            w_occ;
   logic                  w_pop;
   logic [2:0]            w_committed;

   assign w_occ   = r_occ;
   assign valid_o = (r_occ != S_EMPTY);
   assign w_pop   = valid_o & ready_i;
   assign data_o  = r_head;
   assign count_o = r_count;
   assign busy_o  = valid_o | r_inflight;

   // Words that will still occupy the buffer after this cycle's pop; a new read is only
   // allowed if there will be room for it when it lands next cycle.
   assign w_committed = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign re_o = srst_n & en_i & ~flush_i & ~empty_i & (w_committed <= 3'd1);

   // Occupancy FSM plus buffer data movement; head is always the oldest word.
   always_ff @(posedge clk_r) begin
      if (!srst_n) begin
         r_occ      <= S_EMPTY;
         r_inflight <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         // re_o is low during flush, so this also drops the outstanding read.
         r_inflight <= re_o;
         if (flush_i) begin
            r_occ <= S_EMPTY;
         end else begin
            case (r_occ)
               S_EMPTY: begin
                  if (r_inflight) begin
                     r_head <= data_r_i;
                     r_occ  <= S_ONE;
                  end
               end
               S_ONE: begin
                  if (r_inflight && !w_pop) begin
                     r_tail <= data_r_i;
                     r_occ  <= S_TWO;
                  end else if (r_inflight && w_pop) begin
                     r_head <= data_r_i;
                  end else if (w_pop) begin
                     r_occ <= S_EMPTY;
                  end
               end
               S_TWO: begin
                  // A landing word without a pop is excluded by the re_o rule.
                  if (w_pop) begin
                     r_head <= r_tail;
                     if (r_inflight) begin
                        r_tail <= data_r_i;
                     end else begin
                        r_occ <= S_ONE;
                     end
                  end
               end
               default: r_occ <= S_EMPTY;
            endcase
         end
      end
   end

   // Delivered-word counter; wraps, survives flush, a pop during flush still counts.
   always_ff @(posedge clk_r) begin
      if (!srst_n) begin
         r_count <= '0;
      end else if (w_pop) begin
         r_count <= r_count + CNT_ONE;
      end
   end

`ifdef AFIFO_RD_STATS_EN
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   // Saturating count of cycles where a word waits on downstream.
   always_ff @(posedge clk_r) begin
      if (!srst_n || flush_i) begin
         r_stall_cnt <= '0;
      end else if (valid_o && !ready_i && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
   end

   assign stall_cnt_o = r_stall_cnt;
   assign underrun_o  = srst_n & en_i & empty_i & (r_occ == S_EMPTY) & ~r_inflight;
`endif

endmodule

// File: doc/afifo_rd_stream.md
Name: afifo_rd_stream

Overview:
- Read-side consumer for the asynchronous FIFO; lives entirely in the read clock domain.
- Pops words from the FIFO read port (re/data/empty) and presents them downstream as a valid/ready stream.
- Hides the FIFO's 1-cycle read latency with a 2-entry output buffer, giving full throughput of one word per cycle.
- Counts delivered words and supports a synchronous flush.

Parameters:
- DATA_WIDTH, 32, width of the FIFO word and the stream data.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk_r  input  1  read-domain clock; all logic is on its rising edge.
- srst_n  input  1  reset, synchronous, active-low.
- en_i  input  1  permits new FIFO reads when high.
- flush_i  input  1  discards buffered and in-flight words.
- empty_i  input  1  FIFO empty flag, read domain.
- data_r_i  input  DATA_WIDTH  FIFO read data; valid 1 cycle after a re_o cycle.
- re_o  output  1  FIFO read enable.
- valid_o  output  1  stream word available.
- ready_i  input  1  downstream accepts the word.
- data_o  output  DATA_WIDTH  stream data (head entry).
- count_o  output  CNT_WIDTH  delivered-word count.
- busy_o  output  1  high when buffer occupancy is nonzero or a read is in flight.

Behaviour:
- Reset (srst_n low at a clk_r edge):
  - occupancy = 0, inflight = 0, count_o = 0, both buffer entries = 0.
  - valid_o = 0, data_o = 0, busy_o = 0.
  - re_o is forced 0 for as long as srst_n is low.
- State machine on occupancy: EMPTY (0), ONE (1), TWO (2). Let pop = valid_o & ready_i and land = inflight.
  - EMPTY: land → ONE.
  - ONE: land & ~pop → TWO; pop & ~land → EMPTY; otherwise stay.
  - TWO: pop & ~land → ONE; pop & land → TWO.
  - TWO & land & ~pop cannot occur, by the re_o rule. Verification asserts this.
- Read issue (combinational): re_o = srst_n & en_i & ~flush_i & ~empty_i & (occupancy + inflight − pop ≤ 1).
- In-flight tracking: inflight <= re_o each cycle. At most 1 read is outstanding.
- Data landing: when inflight = 1, data_r_i is written to the tail entry. If the buffer is empty, or is popped that same cycle with occupancy 1, it goes straight to the head.
- Ordering: strict FIFO order is preserved. With 2 entries, the head is always the oldest word.
- Output: valid_o = (occupancy ≠ 0). data_o = head entry; it holds stable while valid_o & ~ready_i.
- Throughput: with the FIFO non-empty, en_i = 1 and ready_i held 1:
  - first valid_o 2 cycles after re_o first asserts (1 cycle FIFO latency + 1 cycle buffer register);
  - thereafter one word per cycle.
- Backpressure: with ready_i = 0, at most 2 words are buffered, after which re_o = 0. No word is ever dropped.
- count_o: increments by 1 on every pop and wraps modulo 2^CNT_WIDTH. It is not cleared by flush_i.
- flush_i (sampled at an edge):
  - occupancy → 0, so valid_o = 0 next cycle;
  - inflight → 0, and the word returning that cycle is discarded;
  - re_o = 0 during the flush cycle;
  - a pop coincident with flush still counts (the word was accepted).
- Reset mid-operation: all state is cleared at the edge and in-flight data is discarded. The FIFO itself is reset separately.
- empty_i rising while a read is in flight: the landing word is still captured (the read was legal when issued).
- en_i low: no new reads; buffered words continue to drain normally.

Optional Feature:
- Macro: AFIFO_RD_STATS_EN.
- Defined:
  - Adds output stall_cnt_o [CNT_WIDTH], which increments each cycle valid_o & ~ready_i and saturates at all-ones.
  - Adds output underrun_o [1], which is high for 1 cycle whenever en_i & empty_i & occupancy = 0 & inflight = 0.
  - Both are cleared by reset and stall_cnt_o is also cleared by flush_i.
- Undefined: neither port exists; core behaviour is identical.

Test Plan:
- Reset and idle: srst_n = 0 for 3 cycles with empty_i = 0 and en_i = 1 → re_o = 0, valid_o = 0, count_o = 0. After release, re_o = 1 on the first cycle.
- Streaming: FIFO preloaded with 0xfeedbeef, 0x00000001..0x00000007; ready_i = 1 → eight words in order on consecutive cycles, first valid_o 2 cycles after the first re_o, count_o = 8, busy_o = 0 afterwards.
- Backpressure: ready_i = 0 with 5 words available → exactly 2 reads issued and valid_o held with data_o = first word. Releasing ready_i then delivers all 5 in order with no gaps beyond the refill.
- Flush with in-flight read: assert flush_i in the cycle after re_o while occupancy = 1 → valid_o = 0 next cycle, the landed word is discarded, count_o unchanged. The next read after flush delivers the following FIFO word.
- Counter wrap: CNT_WIDTH = 4, deliver 17 words → count_o = 1.
- Stats (AFIFO_RD_STATS_EN defined): hold ready_i = 0 for 6 cycles with valid_o = 1 → stall_cnt_o = 6. With empty_i = 1, en_i = 1 and the buffer empty → underrun_o = 1 each such cycle.
